// File: rtl/spike_decoder_pkg.sv
// spike_decoder_pkg
// Shared definitions for the spike decoder:
//   ISI_W / ISI_MAX         - width and saturation ceiling of the inter-spike interval
//   DEFAULT_WINDOW_CYCLES   - default rate-measurement window length
//   isi_state_e             - ISI tracker states (IDLE: no prior event, ARMED: prior event seen)
//   isi_inc()               - 17-bit increment; bit 16 flags that the result passed ISI_MAX
package spike_decoder_pkg;

    localparam int ISI_W = 16;
    localparam logic [ISI_W-1:0] ISI_MAX = 16'hFFFF;
    localparam int DEFAULT_WINDOW_CYCLES = 1000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } isi_state_e;

    // The carry bit of the widened sum is the saturation indicator.
    function automatic logic [ISI_W:0] isi_inc(input logic [ISI_W-1:0] value);
        return {1'b0, value} + 17'd1;
    endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// spike_edge_detect
// Registers the spike level every cycle (independent of ena) and produces a
// single-cycle event pulse on each enabled 0->1 transition. Because the
// history register keeps tracking while disabled, a level held high across a
// re-enable is never reported as an event.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - qualifies the event pulse
//   spike_in     - spike level from the neuron
//   event_pulse  - high for the cycle in which a qualified rising edge is seen
module spike_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic spike_in,
    output logic event_pulse
);

    logic prev_r;

    // Level history register, deliberately not gated by ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= spike_in;
        end
    end

    assign event_pulse = spike_in & ~prev_r & ena;

endmodule

// File: rtl/spike_decoder.sv
// spike_decoder
// Measures neuron firing: the number of spike events per fixed window of
// WINDOW_CYCLES enabled clocks (rate) and, optionally, the interval between
// the last two events (isi).
// Optional feature macro: SPIKE_DECODER_ISI_EN enables the ISI tracker; when
// undefined, isi and isi_valid are tied to zero and sat reflects rate only.
// Parameters:
//   WINDOW_CYCLES - window length in enabled cycles (2..65535)
//   RATE_W        - width of the saturating spike count
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ena         - low freezes all counters and the ISI tracker
//   spike_in    - spike level; each 0->1 transition is one event
//   rate        - count of the last completed window (held between updates)
//   rate_valid  - one-cycle pulse when rate updates
//   isi         - interval in enabled cycles between the last two events
//   isi_valid   - one-cycle pulse when isi updates
//   sat         - sticky: a rate or isi saturation has occurred since reset
module spike_decoder
    import spike_decoder_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int RATE_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              spike_in,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic [15:0]       isi,
    output logic              isi_valid,
    output logic              sat
);

    localparam logic [15:0]       WIN_LAST = 16'(WINDOW_CYCLES - 1);
    localparam logic [RATE_W-1:0] RATE_MAX = {RATE_W{1'b1}};
    localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1'b1);

    logic              event_s;
    logic [15:0]       win_cnt_r;
    logic              win_last_s;
    logic [RATE_W-1:0] cnt_r;
    logic [RATE_W-1:0] cnt_inc_s;
    logic              rate_ovf_s;
    logic [RATE_W-1:0] rate_r;
    logic              rate_valid_r;
    logic              isi_ovf_s;
    logic              sat_r;

    spike_edge_detect u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .spike_in    (spike_in),
        .event_pulse (event_s)
    );

    assign win_last_s = (win_cnt_r == WIN_LAST);

    // Window position counter: 0..WINDOW_CYCLES-1 over enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r <= 16'd0;
        end else if (ena) begin
            if (win_last_s) begin
                win_cnt_r <= 16'd0;
            end else begin
                win_cnt_r <= win_cnt_r + 16'd1;
            end
        end
    end

    // Saturating spike-count increment; an event arriving at the ceiling is an overflow.
    always_comb begin
        cnt_inc_s  = cnt_r;
        rate_ovf_s = 1'b0;
        if (event_s) begin
            if (cnt_r == RATE_MAX) begin
                rate_ovf_s = 1'b1;
            end else begin
                cnt_inc_s = cnt_r + RATE_ONE;
            end
        end else begin
            cnt_inc_s = cnt_r;
        end
    end

    // Spike counter and rate output; an event on the terminal cycle lands in the closing window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= {RATE_W{1'b0}};
            rate_r       <= {RATE_W{1'b0}};
            rate_valid_r <= 1'b0;
        end else begin
            rate_valid_r <= 1'b0;
            if (ena) begin
                if (win_last_s) begin
                    rate_r       <= cnt_inc_s;
                    rate_valid_r <= 1'b1;
                    cnt_r        <= {RATE_W{1'b0}};
                end else begin
                    cnt_r <= cnt_inc_s;
                end
            end
        end
    end

    assign rate       = rate_r;
    assign rate_valid = rate_valid_r;

`ifdef SPIKE_DECODER_ISI_EN
    isi_state_e       state_r;
    isi_state_e       state_nxt_s;
    logic [ISI_W-1:0] ivl_r;
    logic [ISI_W-1:0] ivl_nxt_s;
    logic [ISI_W:0]   ivl_inc_s;
    logic             isi_load_s;
    logic [ISI_W-1:0] isi_val_s;
    logic [ISI_W-1:0] isi_r;
    logic             isi_valid_r;

    // ISI tracker state and interval counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ivl_r   <= {ISI_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ivl_r   <= ivl_nxt_s;
        end
    end

    // ISI next state: the interval reported is counter+1 because the event cycle itself counts.
    always_comb begin
        state_nxt_s = state_r;
        ivl_nxt_s   = ivl_r;
        ivl_inc_s   = isi_inc(ivl_r);
        isi_load_s  = 1'b0;
        isi_val_s   = ivl_r;
        isi_ovf_s   = 1'b0;
        if (ena) begin
            case (state_r)
                IDLE: begin
                    if (event_s) begin
                        state_nxt_s = ARMED;
                        ivl_nxt_s   = {ISI_W{1'b0}};
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARMED: begin
                    if (event_s) begin
                        isi_load_s = 1'b1;
                        ivl_nxt_s  = {ISI_W{1'b0}};
                        if (ivl_inc_s[ISI_W]) begin
                            isi_val_s = ISI_MAX;
                            isi_ovf_s = 1'b1;
                        end else begin
                            isi_val_s = ivl_inc_s[ISI_W-1:0];
                        end
                    end else if (ivl_inc_s[ISI_W]) begin
                        ivl_nxt_s = ISI_MAX;
                    end else begin
                        ivl_nxt_s = ivl_inc_s[ISI_W-1:0];
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    ivl_nxt_s   = {ISI_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Registered isi result and its update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_r       <= {ISI_W{1'b0}};
            isi_valid_r <= 1'b0;
        end else begin
            isi_valid_r <= isi_load_s;
            if (isi_load_s) begin
                isi_r <= isi_val_s;
            end
        end
    end

    assign isi       = isi_r;
    assign isi_valid = isi_valid_r;
`else
    assign isi       = 16'h0000;
    assign isi_valid = 1'b0;
    assign isi_ovf_s = 1'b0;
`endif

    // Sticky saturation flag covering rate and isi overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else begin
            sat_r <= sat_r | rate_ovf_s | isi_ovf_s;
        end
    end

    assign sat = sat_r;

endmodule

// File: tb/tb_spike_decoder.sv
// Self-checking bench for spike_decoder: two instances (RATE_W=8 and RATE_W=2)
// share the stimulus; a window/timestamp model predicts every output each cycle.
module tb_spike_decoder;

    localparam int W = 10;
`ifdef SPIKE_DECODER_ISI_EN
    localparam bit ISI_ON = 1'b1;
`else
    localparam bit ISI_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        spike;
    logic [7:0]  rate_a;
    logic        rv_a;
    logic [15:0] isi_a;
    logic        iv_a;
    logic        sat_a;
    logic [1:0]  rate_b;
    logic        rv_b;
    logic [15:0] isi_b;
    logic        iv_b;
    logic        sat_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: t counts enabled cycles since reset.
    int t;
    int last_t;
    bit armed;
    int win_ev;
    bit m_prev;
    int e_rate_a, e_rate_b, e_isi;
    bit e_rv, e_iv, e_sat_a, e_sat_b;

    spike_decoder #(.WINDOW_CYCLES(W), .RATE_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike),
        .rate(rate_a), .rate_valid(rv_a), .isi(isi_a), .isi_valid(iv_a), .sat(sat_a)
    );

    spike_decoder #(.WINDOW_CYCLES(W), .RATE_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike),
        .rate(rate_b), .rate_valid(rv_b), .isi(isi_b), .isi_valid(iv_b), .sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; last_t = 0; armed = 1'b0; win_ev = 0; m_prev = 1'b0;
        e_rate_a = 0; e_rate_b = 0; e_isi = 0;
        e_rv = 1'b0; e_iv = 1'b0; e_sat_a = 1'b0; e_sat_b = 1'b0;
    endtask

    task automatic chk_all(input string ph);
        chk({ph, "_rate_a"}, {24'd0, rate_a}, e_rate_a);
        chk({ph, "_rv_a"},   {31'd0, rv_a},   {31'd0, e_rv});
        chk({ph, "_isi_a"},  {16'd0, isi_a},  e_isi);
        chk({ph, "_iv_a"},   {31'd0, iv_a},   {31'd0, e_iv});
        chk({ph, "_sat_a"},  {31'd0, sat_a},  {31'd0, e_sat_a});
        chk({ph, "_rate_b"}, {30'd0, rate_b}, e_rate_b);
        chk({ph, "_rv_b"},   {31'd0, rv_b},   {31'd0, e_rv});
        chk({ph, "_isi_b"},  {16'd0, isi_b},  e_isi);
        chk({ph, "_iv_b"},   {31'd0, iv_b},   {31'd0, e_iv});
        chk({ph, "_sat_b"},  {31'd0, sat_b},  {31'd0, e_sat_b});
    endtask

    // One clock: predict from the current inputs, clock, then compare.
    task automatic tick();
        bit ev;
        int d;
        ev = ena && spike && !m_prev;
        m_prev = spike;
        e_rv = 1'b0;
        e_iv = 1'b0;
        if (ena) begin
            if (ev) begin
                win_ev++;
                if (win_ev > 255) e_sat_a = 1'b1;
                if (win_ev > 3)   e_sat_b = 1'b1;
                if (ISI_ON && armed) begin
                    d = t - last_t;
                    e_isi = (d > 65535) ? 65535 : d;
                    e_iv = 1'b1;
                    if (d > 65535) begin
                        e_sat_a = 1'b1;
                        e_sat_b = 1'b1;
                    end
                end
                armed = 1'b1;
                last_t = t;
            end
            if (t % W == W - 1) begin
                e_rate_a = (win_ev > 255) ? 255 : win_ev;
                e_rate_b = (win_ev > 3) ? 3 : win_ev;
                win_ev = 0;
                e_rv = 1'b1;
            end
            t++;
        end
        @(posedge clk);
        #1;
        chk_all("cyc");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("rst_now");
        @(posedge clk);
        #1;
        chk_all("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic align();
        spike = 1'b0;
        for (int k = 0; k < W && (t % W) != 0; k++) tick();
        if (!ena) begin
            ena = 1'b1;
            for (int k = 0; k < W && (t % W) != 0; k++) tick();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        ena   = 1'b0;
        spike = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Pulse every 4 cycles from release: events 0,4,8 -> rate 3 at cycle 10.
        ena = 1'b1;
        for (int i = 0; i < 24; i++) begin
            spike = (i % 4 == 0);
            tick();
            if (i == 9) begin
                chk("win1_rate", {24'd0, rate_a}, 32'd3);
                chk("win1_valid", {31'd0, rv_a}, 32'd1);
            end
`ifdef SPIKE_DECODER_ISI_EN
            if (i == 4 || i == 8) begin
                chk("isi4_val", {16'd0, isi_a}, 32'd4);
                chk("isi4_valid", {31'd0, iv_a}, 32'd1);
            end
`endif
        end

        // Event on terminal cycle counts in the closing window.
        align();
        for (int p = 0; p < 2 * W; p++) begin
            spike = (p == 3 || p == W - 1);
            tick();
            if (p == W - 1) chk("term_rate", {24'd0, rate_a}, 32'd2);
            if (p == 2 * W - 1) chk("next_win_rate", {24'd0, rate_a}, 32'd0);
        end

        // Five events in one window saturate the 2-bit instance.
        align();
        for (int p = 0; p < W; p++) begin
            spike = (p % 2 == 0) && (p < W - 1);
            tick();
        end
        chk("sat5_rate_b", {30'd0, rate_b}, 32'd3);
        chk("sat5_sat_b", {31'd0, sat_b}, 32'd1);
        chk("sat5_rate_a", {24'd0, rate_a}, 32'd5);
        spike = 1'b0;
        for (int p = 0; p < 2 * W; p++) tick();
        chk("sat_sticky_b", {31'd0, sat_b}, 32'd1);

        // Level held high across an ena drop: no event, no advance, no pulses.
        spike = 1'b1;
        tick();
        tick();
        ena = 1'b0;
        for (int p = 0; p < 13; p++) begin
            tick();
            chk("ena0_rv", {31'd0, rv_a}, 32'd0);
            chk("ena0_iv", {31'd0, iv_a}, 32'd0);
        end
        ena = 1'b1;
        for (int p = 0; p < 5; p++) tick();
        spike = 1'b0;
        for (int p = 0; p < 5; p++) tick();

        // Randomised traffic with occasional disables.
        for (int i = 0; i < 3000; i++) begin
            ena   = ($urandom_range(0, 9) != 0);
            spike = ($urandom_range(0, 2) == 0);
            tick();
        end

        // Long silence while armed saturates the interval.
        do_reset();
        ena = 1'b1;
        spike = 1'b1;
        tick();
        spike = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        spike = 1'b1;
        tick();
`ifdef SPIKE_DECODER_ISI_EN
        chk("isi_sat_val", {16'd0, isi_a}, 32'h0000FFFF);
        chk("isi_sat_flag", {31'd0, sat_a}, 32'd1);
`endif
        spike = 1'b0;
        tick();

        // Reset mid-window with count 5 after a window reporting 3.
        align();
        for (int p = 0; p < W; p++) begin
            spike = (p == 1 || p == 4 || p == 7);
            tick();
        end
        chk("pre_rst_rate", {24'd0, rate_a}, 32'd3);
        for (int p = 0; p < 9; p++) begin
            spike = (p % 2 == 0);
            tick();
        end
        do_reset();
        chk("post_rst_rate", {24'd0, rate_a}, 32'd0);
        chk("post_rst_sat", {31'd0, sat_a}, 32'd0);

        // After release: full-length first window; first event only arms.
        ena = 1'b1;
        for (int i = 0; i < 3 * W; i++) begin
            spike = (i % 3 == 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
